// File: rtl/stopwatch_spi_display.sv
// rtl/stopwatch_spi_display.sv - MAX7219-style SPI display driver for the stopwatch
// Sends the 5-frame init sequence, then refreshes digits 1-6 from a per-pass snapshot.
module stopwatch_spi_display #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ena,
    input  logic [3:0] ces_0X,
    input  logic [3:0] ces_X0,
    input  logic [3:0] sec_0X,
    input  logic [2:0] sec_X0,
    input  logic [3:0] min_0X,
    input  logic [2:0] min_X0,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       init_done
);
    typedef enum logic [1:0] {ST_INIT, ST_REFRESH, ST_HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d, saved_q, saved_d, st_start, st_next;
    logic [2:0]  idx_q, idx_d, idx_start, idx_next;
    logic        busy_q, busy_d, start;
    logic [5:0]  slot_q, slot_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] frame_q, frame_d;
    logic [21:0] snap_q, snap_d, live_snap;
    logic        init_done_q, init_done_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic [3:0]  bit_sel;

    // Snapshot layout: {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X}
    function automatic logic [15:0] frame_word(input state_t st, input logic [2:0] idx,
                                               input logic [21:0] s);
        logic [15:0] w;
        if (st == ST_INIT) begin
            case (idx)
                3'd0:    w = 16'h09FF;
                3'd1:    w = 16'h0A08;
                3'd2:    w = 16'h0B05;
                3'd3:    w = 16'h0C01;
                default: w = 16'h0F00;
            endcase
        end else begin
            case (idx)
                3'd0:    w = {8'h01, 4'h0, s[3:0]};
                3'd1:    w = {8'h02, 4'h0, s[7:4]};
                3'd2:    w = {8'h03, 4'h8, s[11:8]};
                3'd3:    w = {8'h04, 5'h00, s[14:12]};
                3'd4:    w = {8'h05, 4'h8, s[18:15]};
                default: w = {8'h06, 5'h00, s[21:19]};
            endcase
        end
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        slot_d      = slot_q;
        div_d       = div_q;
        frame_d     = frame_q;
        snap_d      = snap_q;
        init_done_d = init_done_q;
        start       = 1'b0;
        st_start    = state_q;
        idx_start   = idx_q;
        st_next     = state_q;
        idx_next    = idx_q;
        live_snap   = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};

        // Sequence advance, only meaningful at the end of a frame
        if (state_q == ST_INIT) begin
            st_next  = (idx_q == 3'd4) ? ST_REFRESH : ST_INIT;
            idx_next = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end else begin
            st_next  = ST_REFRESH;
            idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        if (busy_q) begin
            if (div_q == DIV_LAST) begin
                div_d = 8'd0;
                if (slot_q == 6'd33) begin
                    if (ena) begin
                        start     = 1'b1;
                        st_start  = st_next;
                        idx_start = idx_next;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_HOLD;
                        saved_d = st_next;
                        idx_d   = idx_next;
                    end
                end else begin
                    slot_d = slot_q + 6'd1;
                end
                if (slot_q == 6'd32 && state_q == ST_INIT && idx_q == 3'd4) begin
                    init_done_d = 1'b1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end else if (ena) begin
            start     = 1'b1;
            st_start  = (state_q == ST_HOLD) ? saved_q : state_q;
            idx_start = idx_q;
        end

        if (start) begin
            busy_d  = 1'b1;
            slot_d  = 6'd0;
            div_d   = 8'd0;
            state_d = st_start;
            idx_d   = idx_start;
            if (st_start == ST_REFRESH && idx_start == 3'd0) begin
                snap_d  = live_snap;
                frame_d = frame_word(st_start, idx_start, live_snap);
            end else begin
                frame_d = frame_word(st_start, idx_start, snap_q);
            end
        end

        // Outputs are decoded from next-state so the pins come straight from flops
        bit_sel = ~slot_d[4:1];
        cs_n_d  = !(busy_d && slot_d < 6'd33);
        sclk_d  = busy_d && slot_d < 6'd32 && slot_d[0];
        mosi_d  = busy_d && slot_d < 6'd32 && frame_d[bit_sel];
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= ST_INIT;
            saved_q     <= ST_INIT;
            idx_q       <= 3'd0;
            busy_q      <= 1'b0;
            slot_q      <= 6'd0;
            div_q       <= 8'd0;
            frame_q     <= 16'h0000;
            snap_q      <= 22'd0;
            init_done_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            slot_q      <= slot_d;
            div_q       <= div_d;
            frame_q     <= frame_d;
            snap_q      <= snap_d;
            init_done_q <= init_done_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_stopwatch_spi_display.sv
// tb/tb_stopwatch_spi_display.sv - directed self-checking bench for stopwatch_spi_display
// Runs a CLK_DIV=4 and a CLK_DIV=1 instance side by side from the same stimulus.
module tb_stopwatch_spi_display;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] ces_0X = 4'd6, ces_X0 = 4'd5, sec_0X = 4'd4, min_0X = 4'd2;
    logic [2:0] sec_X0 = 3'd3, min_X0 = 3'd1;
    logic       sclk4, mosi4, cs4, idn4;
    logic       sclk1, mosi1, cs1, idn1;

    always #5 clk = ~clk;

    stopwatch_spi_display #(.CLK_DIV(4)) dut4 (
        .clk(clk), .res(res), .ena(ena),
        .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
        .min_0X(min_0X), .min_X0(min_X0),
        .sclk(sclk4), .mosi(mosi4), .cs_n(cs4), .init_done(idn4)
    );

    stopwatch_spi_display #(.CLK_DIV(1)) dut1 (
        .clk(clk), .res(res), .ena(ena),
        .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
        .min_0X(min_0X), .min_X0(min_X0),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs1), .init_done(idn1)
    );

    typedef struct {
        logic [15:0] w;
        int          edges;
        logic        idn;
        int          fall;
    } frame_t;

    frame_t q4[$];
    frame_t q1[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int unstable4 = 0;
    int unstable1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver models: decode frames by sampling on sclk rising
    initial begin : mon4
        logic p_cs, p_sclk, p_mosi, in_f;
        logic [15:0] sh;
        int ed, fall;
        frame_t f;
        p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; in_f = 1'b0; sh = 16'h0; ed = 0; fall = 0;
        forever begin
            @(negedge clk);
            if (res) begin
                in_f = 1'b0;
            end else begin
                if (!cs4 && p_cs) begin
                    in_f = 1'b1; sh = 16'h0; ed = 0; fall = cyc;
                end
                if (in_f && !cs4 && sclk4 && !p_sclk) begin
                    sh = {sh[14:0], mosi4}; ed++;
                    if (mosi4 !== p_mosi) unstable4++;
                end
                if (in_f && cs4 && !p_cs) begin
                    f.w = sh; f.edges = ed; f.idn = idn4; f.fall = fall;
                    q4.push_back(f);
                    in_f = 1'b0;
                end
            end
            p_cs = cs4; p_sclk = sclk4; p_mosi = mosi4;
        end
    end

    initial begin : mon1
        logic p_cs, p_sclk, p_mosi, in_f;
        logic [15:0] sh;
        int ed, fall;
        frame_t f;
        p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; in_f = 1'b0; sh = 16'h0; ed = 0; fall = 0;
        forever begin
            @(negedge clk);
            if (res) begin
                in_f = 1'b0;
            end else begin
                if (!cs1 && p_cs) begin
                    in_f = 1'b1; sh = 16'h0; ed = 0; fall = cyc;
                end
                if (in_f && !cs1 && sclk1 && !p_sclk) begin
                    sh = {sh[14:0], mosi1}; ed++;
                    if (mosi1 !== p_mosi) unstable1++;
                end
                if (in_f && cs1 && !p_cs) begin
                    f.w = sh; f.edges = ed; f.idn = idn1; f.fall = fall;
                    q1.push_back(f);
                    in_f = 1'b0;
                end
            end
            p_cs = cs1; p_sclk = sclk1; p_mosi = mosi1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_frame(input int sel, output frame_t f);
        int n = 0;
        while (((sel == 4) ? q4.size() : q1.size()) == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (((sel == 4) ? q4.size() : q1.size()) == 0) begin
            total++;
            bad++;
            $error("FAIL frame_timeout observed=none expected=frame dut%0d", sel);
            f.w = 16'hxxxx; f.edges = -1; f.idn = 1'bx; f.fall = 0;
        end else if (sel == 4) begin
            f = q4.pop_front();
        end else begin
            f = q1.pop_front();
        end
    endtask

    task automatic wait_cs4_low();
        int n = 0;
        while (cs4 !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cs4_fall_seen", {31'd0, cs4}, 32'd0);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        frame_t f;
        int prev_fall;
        int lows;
        int badedge;
        logic [15:0] init_w[5];
        logic [15:0] ref_w[6];
        init_w = '{16'h09FF, 16'h0A08, 16'h0B05, 16'h0C01, 16'h0F00};
        ref_w  = '{16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0582, 16'h0601};

        repeat (3) @(negedge clk);
        check("rst_sclk", {31'd0, sclk4}, 32'd0);
        check("rst_mosi", {31'd0, mosi4}, 32'd0);
        check("rst_cs_n", {31'd0, cs4}, 32'd1);
        check("rst_init_done", {31'd0, idn4}, 32'd0);

        drive_edge();
        res = 1'b0;

        // Init sequence, frame period and init_done timing
        prev_fall = 0;
        for (int i = 0; i < 5; i++) begin
            get_frame(4, f);
            check($sformatf("init_word%0d", i), {16'd0, f.w}, {16'd0, init_w[i]});
            check($sformatf("init_edges%0d", i), f.edges, 16);
            check($sformatf("init_done_at%0d", i), {31'd0, f.idn}, (i == 4) ? 32'd1 : 32'd0);
            if (i > 0) check($sformatf("init_period%0d", i), f.fall - prev_fall, 136);
            prev_fall = f.fall;
        end

        // First refresh pass; ces_0X changes mid 0x02 frame
        get_frame(4, f);
        check("ref_word0", {16'd0, f.w}, {16'd0, ref_w[0]});
        check("ref_period0", f.fall - prev_fall, 136);
        wait_cs4_low();
        repeat (40) @(negedge clk);
        ces_0X = 4'd7;
        for (int i = 1; i < 6; i++) begin
            get_frame(4, f);
            check($sformatf("ref_word%0d", i), {16'd0, f.w}, {16'd0, ref_w[i]});
            check($sformatf("ref_edges%0d", i), f.edges, 16);
        end
        check("init_done_held", {31'd0, idn4}, 32'd1);

        // Second pass picks up the new snapshot
        get_frame(4, f);
        check("pass2_word0", {16'd0, f.w}, 32'h0107);
        get_frame(4, f);
        check("pass2_word1", {16'd0, f.w}, 32'h0205);

        // ena dropped mid-frame: frame completes, then hold, then resume in sequence
        wait_cs4_low();
        repeat (30) @(negedge clk);
        ena = 1'b0;
        get_frame(4, f);
        check("hold_last_word", {16'd0, f.w}, 32'h0384);
        check("hold_last_edges", f.edges, 16);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (cs4 !== 1'b1) lows++;
        end
        check("hold_cs_high", lows, 0);
        check("hold_no_frames", q4.size(), 0);
        drive_edge();
        ena = 1'b1;
        get_frame(4, f);
        check("resume_word", {16'd0, f.w}, 32'h0403);

        // Async reset around bit 8 of the following refresh frame
        wait_cs4_low();
        repeat (57) @(negedge clk);
        check("pre_reset_cs_low", {31'd0, cs4}, 32'd0);
        drive_edge();
        res = 1'b1;
        #1;
        check("arst_cs_n", {31'd0, cs4}, 32'd1);
        check("arst_sclk", {31'd0, sclk4}, 32'd0);
        check("arst_mosi", {31'd0, mosi4}, 32'd0);
        check("arst_init_done", {31'd0, idn4}, 32'd0);

        // CLK_DIV=1 frames recorded so far must all be full 16-edge frames
        badedge = 0;
        foreach (q1[i]) if (q1[i].edges != 16) badedge++;
        check("div1_edges_all16", badedge, 0);
        check("div1_frames_seen", (q1.size() >= 20) ? 32'd1 : 32'd0, 32'd1);
        check("div1_mosi_stable", unstable1, 0);
        check("div4_mosi_stable", unstable4, 0);

        repeat (3) @(negedge clk);
        q4.delete();
        q1.delete();
        drive_edge();
        res = 1'b0;

        get_frame(4, f);
        check("post_rst_word0", {16'd0, f.w}, 32'h09FF);
        get_frame(4, f);
        check("post_rst_word1", {16'd0, f.w}, 32'h0A08);

        // CLK_DIV=1 decode after reset: full init then a refresh pass
        prev_fall = 0;
        for (int i = 0; i < 11; i++) begin
            get_frame(1, f);
            check($sformatf("div1_word%0d", i), {16'd0, f.w},
                  (i < 5) ? {16'd0, init_w[i]} : ((i == 5) ? 32'h0107 : {16'd0, ref_w[i-5]}));
            check($sformatf("div1_edges%0d", i), f.edges, 16);
            if (i > 0) check($sformatf("div1_period%0d", i), f.fall - prev_fall, 34);
            if (i == 4) check("div1_init_done", {31'd0, f.idn}, 32'd1);
            prev_fall = f.fall;
        end
        check("div1_mosi_stable_end", unstable1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
